// File: rtl/const_pattern_gen_pkg.sv
// Shared types for the constant/pattern burst generator: pattern modes and FSM states.
package cpg_pkg;

  localparam int CPG_MODE_W = 2;

  typedef enum logic [CPG_MODE_W-1:0] {
    CPG_CONST = 2'd0,
    CPG_WALK  = 2'd1,
    CPG_COUNT = 2'd2,
    CPG_ALT   = 2'd3
  } cpg_mode_t;

  typedef enum logic [1:0] {
    CPG_IDLE = 2'd0,
    CPG_RUN  = 2'd1,
    CPG_DONE = 2'd2
  } cpg_state_t;

endpackage

// File: rtl/cpg_pattern_next.sv
// Combinational successor of the current pattern word for the selected mode.
module cpg_pattern_next
  import cpg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  cpg_mode_t        mode,
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] next
);

  always_comb begin
    next = cur;
    case (mode)
      CPG_CONST: next = cur;
      CPG_WALK:  next = {cur[WIDTH-2:0], cur[WIDTH-1]};
      CPG_COUNT: next = cur + WIDTH'(1);
      CPG_ALT:   next = ~cur;
      default:   next = cur;
    endcase
  end

endmodule

// File: rtl/const_pattern_gen.sv
// Burst pattern source on a valid/ready stream; 1-cycle start-to-valid, words hold under backpressure.
// CPG_IDLE_ONE_EN: out_data rests at CONST_VAL instead of 0 whenever out_valid is low.
module const_pattern_gen
  import cpg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               LEN_W     = 8,
  parameter logic [WIDTH-1:0] CONST_VAL = {WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [CPG_MODE_W-1:0] mode,
  input  logic [LEN_W-1:0]      len,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  busy,
  output logic                  done
);

`ifdef CPG_IDLE_ONE_EN
  localparam logic [WIDTH-1:0] IDLE_DATA = CONST_VAL;
`else
  localparam logic [WIDTH-1:0] IDLE_DATA = '0;
`endif

  cpg_state_t       state_q, state_d;
  cpg_mode_t        mode_q, mode_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  cpg_mode_t        mode_in;
  logic [WIDTH-1:0] first_pat;
  logic [WIDTH-1:0] pat_next;
  logic             xfer;

  assign mode_in = cpg_mode_t'(mode);
  assign xfer    = valid_q && out_ready;

  always_comb begin
    first_pat = '0;
    case (mode_in)
      CPG_CONST: first_pat = CONST_VAL;
      CPG_WALK:  first_pat = WIDTH'(1);
      CPG_COUNT: first_pat = '0;
      CPG_ALT:   first_pat = CONST_VAL;
      default:   first_pat = '0;
    endcase
  end

  // The output register doubles as the pattern state while in RUN.
  cpg_pattern_next #(
    .WIDTH(WIDTH)
  ) u_pattern_next (
    .mode(mode_q),
    .cur (data_q),
    .next(pat_next)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      CPG_IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        data_d  = IDLE_DATA;
        if (start) begin
          mode_d = mode_in;
          if (len != '0) begin
            state_d = CPG_RUN;
            rem_d   = len;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            data_d  = first_pat;
          end else begin
            state_d = CPG_DONE;
            done_d  = 1'b1;
          end
        end
      end
      CPG_RUN: begin
        if (xfer) begin
          if (rem_q == LEN_W'(1)) begin
            state_d = CPG_DONE;
            rem_d   = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            data_d  = IDLE_DATA;
            done_d  = 1'b1;
          end else begin
            rem_d  = rem_q - LEN_W'(1);
            data_d = pat_next;
          end
        end
      end
      CPG_DONE: begin
        state_d = CPG_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        data_d  = IDLE_DATA;
      end
      default: begin
        state_d = CPG_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        data_d  = IDLE_DATA;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= CPG_IDLE;
      mode_q  <= CPG_CONST;
      rem_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= IDLE_DATA;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_const_pattern_gen.sv
// Scoreboard bench for const_pattern_gen: expected beats and done markers queued at stimulus time.
module tb_const_pattern_gen;

  localparam int          DONE_MARK = 256;
  localparam logic [7:0]  CV        = 8'hFF;
`ifdef CPG_IDLE_ONE_EN
  localparam logic [7:0]  IDLE_EXP  = 8'hFF;
`else
  localparam logic [7:0]  IDLE_EXP  = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] len = 8'd0;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [7:0] out_data;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;
  int done_cnt = 0;
  int exp_q[$];
  bit rdy_q[$];
  bit rdy_rand = 1'b0;

  bit         prev_stall = 1'b0;
  logic [7:0] prev_dat = 8'h00;

  const_pattern_gen #(
    .WIDTH    (8),
    .LEN_W    (8),
    .CONST_VAL(8'hFF)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .mode     (mode),
    .len      (len),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: beat i of a burst, straight from the pattern definitions.
  function automatic logic [7:0] model_word(input int m, input int i);
    logic [7:0] one;
    one = 8'd1;
    case (m)
      0:       return CV;
      1:       return one << (i % 8);
      2:       return 8'(i % 256);
      default: return (i % 2 == 0) ? CV : ~CV;
    endcase
  endfunction

  task automatic start_burst(input int m, input int l);
    for (int i = 0; i < l; i++) exp_q.push_back(int'(model_word(m, i)));
    exp_q.push_back(DONE_MARK);
    @(posedge clk); #1;
    start = 1'b1;
    mode  = 2'(m);
    len   = 8'(l);
    @(posedge clk); #1;
    start = 1'b0;
    mode  = 2'($urandom);
    len   = 8'($urandom);
  endtask

  task automatic wait_done(input int target);
    int cyc;
    cyc = 0;
    while (done_cnt < target && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_reached", 32'(done_cnt >= target), 32'd1);
  endtask

  // Ready driver: scheduled values first, else random or held high.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_q.size() > 0) out_ready = rdy_q.pop_front();
      else if (rdy_rand)    out_ready = 1'($urandom_range(0, 1));
      else                  out_ready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every transfer and done pulse.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_data", 32'(out_data), 32'(prev_dat));
        end
        if (out_valid) chk("busy_with_valid", 32'(busy), 32'd1);
        if (out_valid && out_ready) begin
          n_xfer++;
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", 32'(out_data), 32'(e));
          end
        end
        if (done) begin
          done_cnt++;
          chk("done_valid_low", 32'(out_valid), 32'd0);
          chk("done_busy_low", 32'(busy), 32'd0);
          chk("done_idle_data", 32'(out_data), 32'(IDLE_EXP));
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd0, 32'(DONE_MARK));
          end else begin
            e = exp_q.pop_front();
            chk("done_position", 32'(DONE_MARK), 32'(e));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_dat   = out_data;
      end
    end
  end

  initial begin
    int tgt;
    int base;
    int cyc;
    int dsave;

    // Reset held with start asserted.
    resetn = 1'b0;
    start  = 1'b1;
    mode   = 2'd1;
    len    = 8'd5;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'(IDLE_EXP));
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
    end
    start  = 1'b0;
    resetn = 1'b1;
    tgt = 0;

    // WALK x10 with ready held high.
    start_burst(1, 10);
    tgt++; wait_done(tgt);

    // COUNT x3 with beat 1 stalled three cycles.
    rdy_q.push_back(1'b1);
    rdy_q.push_back(1'b1);
    rdy_q.push_back(1'b0);
    rdy_q.push_back(1'b0);
    rdy_q.push_back(1'b0);
    start_burst(2, 3);
    tgt++; wait_done(tgt);

    // ALT x4 with a start pulse mid-burst that must be ignored.
    start_burst(3, 4);
    @(posedge clk); #1;
    start = 1'b1; mode = 2'd2; len = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    tgt++; wait_done(tgt);

    // Back-to-back start right after done.
    start_burst(0, 3);
    tgt++; wait_done(tgt);

    // Zero-length burst: only a done pulse.
    start_burst(2, 0);
    tgt++; wait_done(tgt);

    // Random bursts with random backpressure, plus a maximum-length WALK.
    rdy_rand = 1'b1;
    for (int k = 0; k < 25; k++) begin
      start_burst(int'($urandom_range(0, 3)), int'($urandom_range(0, 24)));
      tgt++; wait_done(tgt);
    end
    start_burst(1, 255);
    tgt++; wait_done(tgt);
    rdy_rand = 1'b0;

    // Reset in the middle of a long COUNT burst.
    base = n_xfer;
    start_burst(2, 200);
    cyc = 0;
    while ((n_xfer - base) < 50 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_beat50", 32'((n_xfer - base) >= 50), 32'd1);
    resetn = 1'b0;
    exp_q.delete();
    dsave = done_cnt;
    @(posedge clk); #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_data", 32'(out_data), 32'(IDLE_EXP));
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_done_after_abort", 32'(done_cnt), 32'(dsave));

    // Fresh burst after the abort restarts from zero.
    start_burst(2, 5);
    wait_done(dsave + 1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
